// File: rtl/proc_batch_ctrl_if.sv
// Bundle of command, byte-stream, processor and result signals for proc_batch_ctrl.
// master is the controller side; slave is the environment (host, source, processor).
interface proc_batch_ctrl_if;
  logic        cmd_start;
  logic [15:0] cmd_str_len;
  logic        cmd_busy;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        proc_start;
  logic [15:0] proc_str_len;
  logic [7:0]  proc_data;
  logic        proc_data_valid;
  logic        proc_last;
  logic        proc_match_char_next;
  logic        proc_done;
  logic        proc_match;
  logic [31:0] proc_byte_pos;
  logic [7:0]  proc_match_char;
  logic        res_valid;
  logic        res_match;
  logic        res_timeout;
  logic [31:0] res_byte_pos;
  logic [31:0] res_byte_count;
  logic [7:0]  res_char;
  logic        res_char_valid;
  logic        res_ack;

  modport master (
    input  cmd_start, cmd_str_len, s_data, s_valid, s_last, proc_done, proc_match,
           proc_byte_pos, proc_match_char, res_ack,
    output cmd_busy, s_ready, proc_start, proc_str_len, proc_data, proc_data_valid, proc_last,
           proc_match_char_next, res_valid, res_match, res_timeout, res_byte_pos,
           res_byte_count, res_char, res_char_valid
  );

  modport slave (
    output cmd_start, cmd_str_len, s_data, s_valid, s_last, proc_done, proc_match,
           proc_byte_pos, proc_match_char, res_ack,
    input  cmd_busy, s_ready, proc_start, proc_str_len, proc_data, proc_data_valid, proc_last,
           proc_match_char_next, res_valid, res_match, res_timeout, res_byte_pos,
           res_byte_count, res_char, res_char_valid
  );
endinterface

// File: rtl/proc_batch_ctrl.sv
// Batch controller: streams bytes into a string processor, waits for its verdict with a
// timeout, reads the matched string out char by char and holds the result until acked.
module proc_batch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  proc_batch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StStart, StStream, StDrain, StReadout, StReport} state_e;

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] str_len_q, str_len_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        last_q, last_d;
  logic        match_q, match_d;
  logic        timeout_q, timeout_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d;
  logic [12:0] n_chars;

  assign n_chars = str_len_q[15:3];

  always_comb begin
    state_d      = state_q;
    str_len_d    = str_len_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    last_d       = 1'b0;
    match_d      = match_q;
    timeout_d    = timeout_q;
    pos_d        = pos_q;
    count_d      = count_q;
    cnt_d        = cnt_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_start) begin
          str_len_d = bus.cmd_str_len;
          count_d   = '0;
          match_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: state_d = StStream;
      StStream: begin
        if (bus.s_valid) begin
          data_d       = bus.s_data;
          data_valid_d = 1'b1;
          last_d       = bus.s_last;
          count_d      = count_q + 32'd1;
          if (bus.s_last) begin
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // A verdict in the same cycle as the timeout limit wins over the timeout.
        if (bus.proc_done) begin
          match_d = bus.proc_match;
          pos_d   = bus.proc_byte_pos;
          if (bus.proc_match && (n_chars != '0)) begin
            cnt_d   = {19'd0, n_chars};
            state_d = StReadout;
          end else begin
            state_d = StReport;
          end
        end else if (cnt_q == TimeoutLast) begin
          timeout_d = 1'b1;
          match_d   = 1'b0;
          state_d   = StReport;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StReadout: begin
        char_d       = bus.proc_match_char;
        char_valid_d = 1'b1;
        cnt_d        = cnt_q - 32'd1;
        if (cnt_q == 32'd1) state_d = StReport;
      end
      StReport: begin
        if (bus.res_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      str_len_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      last_q       <= 1'b0;
      match_q      <= 1'b0;
      timeout_q    <= 1'b0;
      pos_q        <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      str_len_q    <= str_len_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      last_q       <= last_d;
      match_q      <= match_d;
      timeout_q    <= timeout_d;
      pos_q        <= pos_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
    end
  end

  assign bus.cmd_busy             = (state_q != StIdle);
  assign bus.s_ready              = (state_q == StStream);
  assign bus.proc_start           = (state_q == StStart);
  assign bus.proc_match_char_next = (state_q == StReadout);
  assign bus.res_valid            = (state_q == StReport);
  assign bus.proc_str_len         = str_len_q;
  assign bus.proc_data            = data_q;
  assign bus.proc_data_valid      = data_valid_q;
  assign bus.proc_last            = last_q;
  assign bus.res_match            = match_q;
  assign bus.res_timeout          = timeout_q;
  assign bus.res_byte_pos         = pos_q;
  assign bus.res_byte_count       = count_q;
  assign bus.res_char             = char_q;
  assign bus.res_char_valid       = char_valid_q;

endmodule

// File: tb/tb_proc_batch_ctrl.sv
// Scoreboard bench for proc_batch_ctrl: the driver pushes expected bytes, chars and results;
// a negedge monitor pops and compares whenever the controller presents them.
module tb_proc_batch_ctrl;
  localparam int unsigned TO = 16;

  typedef struct {
    logic        match;
    logic        timeout;
    logic [31:0] pos;
    logic        chk_pos;
    logic [31:0] count;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proc_batch_ctrl_if bus();

  proc_batch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_data_q[$];
  logic [7:0] exp_char_q[$];
  res_t       exp_res_q[$];

  int n_start = 0;
  int n_next  = 0;

  // Processor model configuration.
  logic        cfg_match = 1'b0;
  logic [31:0] cfg_pos   = '0;
  int          cfg_delay = 1;
  bit          cfg_hang  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // String processor model; proc_done stays high until the next proc_start.
  initial begin : proc_model
    int done_cnt;
    int char_idx;
    done_cnt = 0;
    char_idx = 0;
    bus.proc_done       = 1'b0;
    bus.proc_match      = 1'b0;
    bus.proc_byte_pos   = '0;
    bus.proc_match_char = 8'h41;
    forever begin
      @(negedge clk);
      if (bus.proc_start) begin
        bus.proc_done = 1'b0;
        char_idx      = 0;
        done_cnt      = 0;
      end
      if (bus.proc_data_valid && bus.proc_last && !cfg_hang) begin
        done_cnt = cfg_delay;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          bus.proc_done     = 1'b1;
          bus.proc_match    = cfg_match;
          bus.proc_byte_pos = cfg_pos;
        end
      end
      bus.proc_match_char = 8'(8'h41 + char_idx);
      if (bus.proc_match_char_next) char_idx++;
    end
  end

  initial begin : monitor
    bit         res_seen;
    logic [8:0] ed;
    logic [7:0] ec;
    res_t       er;
    res_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.proc_start) n_start++;
      if (bus.proc_match_char_next) n_next++;
      if (bus.proc_data_valid) begin
        if (exp_data_q.size() == 0) check("unexpected_proc_data_valid", 1, 0);
        else begin
          ed = exp_data_q.pop_front();
          check("proc_data", bus.proc_data, {24'd0, ed[7:0]});
          check("proc_last", bus.proc_last, {31'd0, ed[8]});
        end
      end
      if (bus.res_char_valid) begin
        if (exp_char_q.size() == 0) check("unexpected_res_char_valid", 1, 0);
        else begin
          ec = exp_char_q.pop_front();
          check("res_char", bus.res_char, {24'd0, ec});
        end
      end
      if (bus.res_valid && !res_seen) begin
        res_seen = 1'b1;
        if (exp_res_q.size() == 0) check("unexpected_res_valid", 1, 0);
        else begin
          er = exp_res_q.pop_front();
          check("res_match", bus.res_match, {31'd0, er.match});
          check("res_timeout", bus.res_timeout, {31'd0, er.timeout});
          check("res_byte_count", bus.res_byte_count, er.count);
          if (er.chk_pos) check("res_byte_pos", bus.res_byte_pos, er.pos);
        end
      end
      if (!bus.res_valid) res_seen = 1'b0;
    end
  end

  // Feeds n bytes with occasional gaps; optionally pulses cmd_start mid-stream.
  task automatic send_bytes(input int n, input bit pulse_cmd, input bit last_at_end);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'((i * 7 + 3) & 255);
      bus.s_last  = last_at_end && (i == n - 1);
      exp_data_q.push_back({bus.s_last, bus.s_data});
      if (pulse_cmd && i == 1) bus.cmd_start = 1'b1;
      guard = 0;
      while (!bus.s_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("s_ready_wait_expired", 0, 1);
      @(negedge clk);
      bus.cmd_start = 1'b0;
      if (i % 4 == 3) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic run_batch(input logic [15:0] len, input int nbytes, input logic m,
                           input logic [31:0] pos, input int delay, input bit hang,
                           input bit mess, input int ack_delay);
    res_t er;
    int   nchars;
    int   guard;
    int   t0;
    cfg_match = m;
    cfg_pos   = pos;
    cfg_delay = delay;
    cfg_hang  = hang;
    nchars    = (!hang && m) ? int'(len[15:3]) : 0;
    for (int k = 0; k < nchars; k++) exp_char_q.push_back(8'(8'h41 + k));
    er.match   = hang ? 1'b0 : m;
    er.timeout = hang;
    er.pos     = pos;
    er.chk_pos = !hang;
    er.count   = nbytes;
    exp_res_q.push_back(er);
    n_start = 0;
    n_next  = 0;

    bus.cmd_start   = 1'b1;
    bus.cmd_str_len = len;
    @(negedge clk);
    bus.cmd_start   = 1'b0;
    bus.cmd_str_len = 16'hffff;
    check("cmd_busy_after_start", bus.cmd_busy, 1);
    check("proc_str_len", bus.proc_str_len, {16'd0, len});
    send_bytes(nbytes, mess, 1'b1);
    t0 = cyc;
    if (mess) begin
      for (int k = 0; k < 4; k++) begin
        bus.s_valid = k[0] ? 1'b0 : 1'b1;
        bus.s_last  = 1'b1;
        @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
    if (hang) begin
      guard = 0;
      while (!bus.res_timeout && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check("timeout_latency", cyc - t0, TO);
    end
    guard = 0;
    while (!bus.res_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("res_valid_seen", bus.res_valid, 1);
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge clk);
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_res_count", bus.res_byte_count, nbytes);
      check("hold_res_match", bus.res_match, {31'd0, er.match});
      check("hold_res_pos", bus.res_byte_pos, pos);
    end
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0;
    check("res_valid_after_ack", bus.res_valid, 0);
    check("cmd_busy_after_ack", bus.cmd_busy, 0);
    check("proc_start_pulses", n_start, 1);
    check("match_char_next_cycles", n_next, nchars);
    check("chars_all_seen", exp_char_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    bus.cmd_start   = 1'b0;
    bus.cmd_str_len = '0;
    bus.s_data      = '0;
    bus.s_valid     = 1'b0;
    bus.s_last      = 1'b0;
    bus.res_ack     = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_busy", bus.cmd_busy, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_byte_count", bus.res_byte_count, 0);
    check("rst_proc_str_len", bus.proc_str_len, 0);
    reset = 1'b0;
    @(negedge clk);

    run_batch(16'd152, 100, 1'b1, 32'd37, 3, 1'b0, 1'b0, 0);  // 19 chars readout
    run_batch(16'd40,  5,   1'b0, 32'd0,  2, 1'b0, 1'b0, 0);  // no match
    run_batch(16'd64,  7,   1'b1, 32'd0,  1, 1'b1, 1'b0, 0);  // processor never done
    run_batch(16'd8,   6,   1'b1, 32'd2, 10, 1'b0, 1'b1, 0);  // stray start / s_valid
    run_batch(16'd16,  4,   1'b1, 32'd9,  2, 1'b0, 1'b0, 10); // slow ack
    run_batch(16'd0,   2,   1'b1, 32'd1,  1, 1'b0, 1'b0, 0);  // match, empty string

    // Abort a batch mid-stream.
    bus.cmd_start   = 1'b1;
    bus.cmd_str_len = 16'd48;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    send_bytes(4, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_in_stream", bus.s_ready, 1);
    reset = 1'b1;
    #1;
    check("arst_cmd_busy", bus.cmd_busy, 0);
    check("arst_s_ready", bus.s_ready, 0);
    check("arst_res_byte_count", bus.res_byte_count, 0);
    check("arst_proc_str_len", bus.proc_str_len, 0);
    check("arst_proc_data_valid", bus.proc_data_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_batch(16'd24, 3, 1'b1, 32'd5, 2, 1'b0, 1'b0, 0);

    check("data_queue_drained", exp_data_q.size(), 0);
    check("res_queue_drained", exp_res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/proc_batch_ctrl.md
PROC_BATCH_CTRL -- requirements
Module: proc_batch_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the max DRAIN-state cycles before a batch is abandoned.
REQ-002 The block SHALL have these ports:
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle pulse that starts a batch.
- cmd_str_len  in  16  string length in bits (multiple of 8).
- cmd_busy  out  1  batch in progress.
- s_data  in  8  input byte stream.
- s_valid  in  1  s_data valid.
- s_last  in  1  final byte of the batch.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- proc_start  out  1  batch start to the string processor.
- proc_str_len  out  16  latched cmd_str_len.
- proc_data  out  8  byte to the string processor.
- proc_data_valid  out  1  proc_data valid.
- proc_last  out  1  marks the last byte.
- proc_match_char_next  out  1  shifts the matched string by one char.
- proc_done  in  1  processor finished checking all hashes.
- proc_match  in  1  target hash found.
- proc_byte_pos  in  32  index of the matching string.
- proc_match_char  in  8  current matched char (MSB char first).
- res_valid  out  1  result held until acknowledged.
- res_match  out  1  match flag.
- res_timeout  out  1  batch abandoned on timeout.
- res_byte_pos  out  32  match position.
- res_byte_count  out  32  bytes accepted in the batch.
- res_char  out  8  matched string char.
- res_char_valid  out  1  res_char valid.
- res_ack  in  1  consumes the result.

Function
REQ-003 The FSM SHALL have states IDLE, START, STREAM, DRAIN, READOUT, REPORT; cmd_busy SHALL be 1 in every state except IDLE.
REQ-004 IDLE: on cmd_start, the block SHALL latch cmd_str_len into proc_str_len, clear res_byte_count, res_match and res_timeout, and go to START; cmd_start in any other state SHALL be ignored.
REQ-005 START: proc_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to STREAM.
REQ-006 STREAM: s_ready SHALL be 1; s_ready SHALL be 0 in all other states.
REQ-007 Each accepted byte SHALL appear on proc_data with proc_data_valid=1 in the following cycle (1-cycle registered latency) and SHALL increment res_byte_count (32-bit, wraps).
REQ-008 Accepting a byte with s_last=1 SHALL assert proc_last in the same registered cycle as that byte's proc_data_valid and move the FSM to DRAIN.
REQ-009 DRAIN: a 32-bit counter SHALL start from 0.
- If proc_done=1: latch proc_match and proc_byte_pos; go to READOUT if proc_match=1 and proc_str_len[15:3]!=0, otherwise go to REPORT.
- If the counter reaches TIMEOUT_CYCLES first: set res_timeout=1, res_match=0, and go to REPORT.
- proc_done SHALL NOT be sampled in any other state (it holds stale high from the previous batch until START).
REQ-010 READOUT: a down-counter SHALL load proc_str_len[15:3]. Each READOUT cycle:
- proc_match_char_next SHALL be 1 (combinational from state).
- res_char SHALL be registered from proc_match_char.
- res_char_valid SHALL be registered 1.
- The counter SHALL decrement; at 1 the FSM SHALL go to REPORT.
Exactly proc_str_len/8 chars SHALL be emitted, one per cycle, first char first, with no backpressure.
REQ-011 REPORT: res_valid SHALL be 1 with res_match, res_timeout, res_byte_pos and res_byte_count stable. On res_ack=1, res_valid SHALL drop the next cycle and the FSM SHALL return to IDLE. res_ack in other states SHALL be ignored.
REQ-012 proc_data_valid, proc_last, proc_start, proc_match_char_next and res_char_valid SHALL be 0 in every cycle not named above.
REQ-013 s_valid=1 outside STREAM SHALL NOT be consumed or counted.

Reset
REQ-014 Asserting reset SHALL, asynchronously:
- put the FSM in IDLE;
- drive all outputs to 0, with proc_str_len, res_byte_pos, res_byte_count and res_char also 0;
- clear all counters, including mid-batch.
REQ-015 After reset deasserts, the first cmd_start SHALL begin a normal batch with no residue from the aborted one.

Verification
REQ-016 str_len=152, 100 bytes, processor reports match at pos 37 → one proc_start pulse, 100 proc_data_valid with proc_last on the 100th, 19 res_char_valid cycles, then res_valid=1, res_match=1, res_byte_pos=37, res_byte_count=100.
REQ-017 No match, 5 bytes → no proc_match_char_next, res_valid with res_match=0, res_byte_count=5, res_timeout=0.
REQ-018 proc_done held low, TIMEOUT_CYCLES=16 → res_timeout=1 exactly 16 cycles after DRAIN entry, res_match=0.
REQ-019 cmd_start pulsed during STREAM and s_valid toggled during DRAIN → no new batch, counts unchanged.
REQ-020 reset asserted mid-STREAM → outputs 0 immediately, cmd_busy=0; next batch of 3 bytes reports res_byte_count=3.
REQ-021 res_ack delayed 10 cycles → res_valid and fields stable for all 10 cycles, IDLE one cycle after ack.
